// File: rtl/divider_issue_controller.sv
// Issue/completion stage for the approximate 32-bit divider core.
// Handles DIV/DIVU/REM/REMU requests, resolves divide-by-zero and signed overflow
// locally, feeds operand magnitudes to the core and sign-corrects its outputs.
module divider_issue_controller #(
    parameter int unsigned CORE_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] operand_1,
    input  logic [31:0] operand_2,
    input  logic [7:0]  accuracy_in,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [31:0] core_input_1,
    output logic [31:0] core_input_2,
    output logic [7:0]  core_accuracy,
    input  logic [31:0] core_result,
    input  logic [31:0] core_remainder
);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    localparam logic [3:0] CountLoad = 4'(CORE_LATENCY - 1);

    state_e      r_state, w_state_next;
    logic [3:0]  r_count, w_count_next;
    logic        r_op_rem, w_op_rem_next;
    logic        r_neg_q, w_neg_q_next;
    logic        r_neg_r, w_neg_r_next;
    logic [31:0] r_result, w_result_next;
    logic [31:0] r_core_in1, w_core_in1_next;
    logic [31:0] r_core_in2, w_core_in2_next;
    logic [7:0]  r_core_acc, w_core_acc_next;

    logic        w_accept;
    logic        w_signed;
    logic        w_div_zero;
    logic        w_overflow;
    logic [31:0] w_mag1;
    logic [31:0] w_mag2;
    logic [31:0] w_core_sel;

    assign w_accept   = (r_state == StIdle) && start && funct3[2];
    assign w_signed   = ~funct3[0];
    assign w_div_zero = (operand_2 == 32'd0);
    assign w_overflow = w_signed && (operand_1 == 32'h8000_0000) && (operand_2 == 32'hFFFF_FFFF);
    // 0x80000000 negates to itself and is then read as an unsigned magnitude
    assign w_mag1     = (w_signed && operand_1[31]) ? -operand_1 : operand_1;
    assign w_mag2     = (w_signed && operand_2[31]) ? -operand_2 : operand_2;
    // Sign correction is applied even to reduced-accuracy core outputs
    assign w_core_sel = r_op_rem ? (r_neg_r ? -core_remainder : core_remainder)
                                 : (r_neg_q ? -core_result : core_result);

    assign busy          = (r_state != StIdle);
    assign result_valid  = (r_state == StDone);
    assign result        = r_result;
    assign core_input_1  = r_core_in1;
    assign core_input_2  = r_core_in2;
    assign core_accuracy = r_core_acc;

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_count    <= 4'd0;
            r_op_rem   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_result   <= 32'd0;
            r_core_in1 <= 32'd0;
            r_core_in2 <= 32'd0;
            r_core_acc <= 8'd0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_op_rem   <= w_op_rem_next;
            r_neg_q    <= w_neg_q_next;
            r_neg_r    <= w_neg_r_next;
            r_result   <= w_result_next;
            r_core_in1 <= w_core_in1_next;
            r_core_in2 <= w_core_in2_next;
            r_core_acc <= w_core_acc_next;
        end
    end

    // Next-state, special-case resolution and result capture
    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_op_rem_next   = r_op_rem;
        w_neg_q_next    = r_neg_q;
        w_neg_r_next    = r_neg_r;
        w_result_next   = r_result;
        w_core_in1_next = r_core_in1;
        w_core_in2_next = r_core_in2;
        w_core_acc_next = r_core_acc;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_op_rem_next = funct3[1];
                    w_neg_q_next  = w_signed && (operand_1[31] ^ operand_2[31]);
                    w_neg_r_next  = w_signed && operand_1[31];
                    if (w_div_zero) begin
                        w_result_next = funct3[1] ? operand_1 : 32'hFFFF_FFFF;
                        w_state_next  = StDone;
                    end else if (w_overflow) begin
                        w_result_next = funct3[1] ? 32'd0 : 32'h8000_0000;
                        w_state_next  = StDone;
                    end else begin
                        w_core_in1_next = w_mag1;
                        w_core_in2_next = w_mag2;
                        w_core_acc_next = accuracy_in;
                        w_count_next    = CountLoad;
                        w_state_next    = StWait;
                    end
                end
            end
            StWait: begin
                if (r_count == 4'd0) begin
                    w_result_next = w_core_sel;
                    w_state_next  = StDone;
                end else begin
                    w_count_next = r_count - 4'd1;
                end
            end
            StDone: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_divider_issue_controller.sv
// Directed bench: table of single requests on a latency-1 instance, plus
// hand sequences on a latency-4 instance for busy-start, approximate core and reset abort.
module tb_divider_issue_controller;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        start1 = 1'b0;
    logic        start4 = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op1 = 32'd0;
    logic [31:0] op2 = 32'd0;
    logic [7:0]  acc = 8'd0;

    logic        busy1, valid1, busy4, valid4;
    logic [31:0] res1, ci1_1, ci2_1, res4, ci1_4, ci2_4;
    logic [7:0]  acc1, acc4;
    logic [31:0] cq1, cr1, cq4, cr4;
    logic        ovr = 1'b0;
    logic [31:0] ovr_q = 32'd0;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    // Ideal core model; dut4 can have its quotient forced to an approximate value
    assign cq1 = (ci2_1 == 32'd0) ? 32'hFFFF_FFFF : ci1_1 / ci2_1;
    assign cr1 = (ci2_1 == 32'd0) ? ci1_1 : ci1_1 % ci2_1;
    assign cq4 = ovr ? ovr_q : ((ci2_4 == 32'd0) ? 32'hFFFF_FFFF : ci1_4 / ci2_4);
    assign cr4 = (ci2_4 == 32'd0) ? ci1_4 : ci1_4 % ci2_4;

    divider_issue_controller #(.CORE_LATENCY(1)) dut1 (
        .CLK(CLK), .reset(reset), .start(start1), .funct3(funct3),
        .operand_1(op1), .operand_2(op2), .accuracy_in(acc),
        .busy(busy1), .result_valid(valid1), .result(res1),
        .core_input_1(ci1_1), .core_input_2(ci2_1), .core_accuracy(acc1),
        .core_result(cq1), .core_remainder(cr1)
    );

    divider_issue_controller #(.CORE_LATENCY(4)) dut4 (
        .CLK(CLK), .reset(reset), .start(start4), .funct3(funct3),
        .operand_1(op1), .operand_2(op2), .accuracy_in(acc),
        .busy(busy4), .result_valid(valid4), .result(res4),
        .core_input_1(ci1_4), .core_input_2(ci2_4), .core_accuracy(acc4),
        .core_result(cq4), .core_remainder(cr4)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  ac;
        logic [31:0] exp_res;
        int          exp_lat;
        logic [31:0] exp_c1;
        logic [31:0] exp_c2;
        logic [7:0]  exp_acc;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        int k;
        int pulses;
        int vk;
        int busy_cnt;
        logic found;

        // exp_lat: edges after the accepting edge before valid is seen
        vecs[0]  = '{3'b101, 32'd100,       32'd7,         8'h00, 32'd14,        1, 32'd100,       32'd7,         8'h00};
        vecs[1]  = '{3'b100, 32'hFFFF_FF9C, 32'd7,         8'h11, 32'hFFFF_FFF2, 1, 32'd100,       32'd7,         8'h11};
        vecs[2]  = '{3'b110, 32'hFFFF_FF9C, 32'd7,         8'h22, 32'hFFFF_FFFE, 1, 32'd100,       32'd7,         8'h22};
        vecs[3]  = '{3'b101, 32'd5,         32'd0,         8'h33, 32'hFFFF_FFFF, 0, 32'd100,       32'd7,         8'h22};
        vecs[4]  = '{3'b110, 32'h8000_0000, 32'd0,         8'h44, 32'h8000_0000, 0, 32'd100,       32'd7,         8'h22};
        vecs[5]  = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 8'h55, 32'h8000_0000, 0, 32'd100,       32'd7,         8'h22};
        vecs[6]  = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 8'h66, 32'd0,         0, 32'd100,       32'd7,         8'h22};
        vecs[7]  = '{3'b101, 32'h8000_0000, 32'd2,         8'h77, 32'h4000_0000, 1, 32'h8000_0000, 32'd2,         8'h77};
        vecs[8]  = '{3'b100, 32'd7,         32'hFFFF_FFFE, 8'h88, 32'hFFFF_FFFD, 1, 32'd7,         32'd2,         8'h88};
        vecs[9]  = '{3'b110, 32'd7,         32'hFFFF_FFFE, 8'h99, 32'd1,         1, 32'd7,         32'd2,         8'h99};
        vecs[10] = '{3'b111, 32'hFFFF_FFFF, 32'h10,        8'hAA, 32'hF,         1, 32'hFFFF_FFFF, 32'h10,        8'hAA};
        vecs[11] = '{3'b100, 32'h8000_0000, 32'd1,         8'hBB, 32'h8000_0000, 1, 32'h8000_0000, 32'd1,         8'hBB};
        vecs[12] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 8'hCC, 32'd0,         1, 32'h8000_0000, 32'hFFFF_FFFF, 8'hCC};

        // Reset state
        @(negedge CLK);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        check("rst_valid", {31'd0, valid1}, 32'd0);
        check("rst_result", res1, 32'd0);
        check("rst_ci1", ci1_1, 32'd0);
        check("rst_ci2", ci2_1, 32'd0);
        check("rst_acc", {24'd0, acc1}, 32'd0);
        reset = 1'b0;

        // Table of single requests on the latency-1 instance
        for (int i = 0; i < 13; i++) begin
            @(negedge CLK);
            funct3 = vecs[i].f3;
            op1    = vecs[i].a;
            op2    = vecs[i].b;
            acc    = vecs[i].ac;
            start1 = 1'b1;
            @(posedge CLK);
            #1 start1 = 1'b0;
            @(negedge CLK);
            check($sformatf("v%0d_busy", i), {31'd0, busy1}, 32'd1);
            k = 0;
            found = valid1;
            while (!found && k < 20) begin
                @(negedge CLK);
                k++;
                found = valid1;
            end
            check($sformatf("v%0d_valid_seen", i), {31'd0, found}, 32'd1);
            check($sformatf("v%0d_lat", i), 32'(k), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_result", i), res1, vecs[i].exp_res);
            check($sformatf("v%0d_ci1", i), ci1_1, vecs[i].exp_c1);
            check($sformatf("v%0d_ci2", i), ci2_1, vecs[i].exp_c2);
            check($sformatf("v%0d_acc", i), {24'd0, acc1}, {24'd0, vecs[i].exp_acc});
            @(negedge CLK);
            check($sformatf("v%0d_valid_drop", i), {31'd0, valid1}, 32'd0);
            check($sformatf("v%0d_busy_drop", i), {31'd0, busy1}, 32'd0);
            check($sformatf("v%0d_result_hold", i), res1, vecs[i].exp_res);
        end

        // Non-divide funct3 is ignored
        @(negedge CLK);
        funct3 = 3'b011;
        op1    = 32'd1;
        op2    = 32'd1;
        start1 = 1'b1;
        @(negedge CLK);
        start1 = 1'b0;
        check("nondiv_busy", {31'd0, busy1}, 32'd0);
        @(negedge CLK);
        check("nondiv_valid", {31'd0, valid1}, 32'd0);
        check("nondiv_result", res1, 32'd0);

        // Latency 4, approximate quotient, start pulses while busy
        @(negedge CLK);
        funct3 = 3'b100;
        op1    = 32'd20;
        op2    = 32'hFFFF_FFFD;
        acc    = 8'd1;
        ovr    = 1'b1;
        ovr_q  = 32'd5;
        start4 = 1'b1;
        @(posedge CLK);
        #1 start4 = 1'b0;
        pulses   = 0;
        vk       = -1;
        busy_cnt = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge CLK);
            if (valid4) begin
                pulses++;
                vk = j;
            end
            if (busy4) busy_cnt++;
            start4 = (j <= 4);
            funct3 = 3'b101;
            op1    = 32'd1;
            op2    = 32'd1;
            acc    = 8'hEE;
        end
        start4 = 1'b0;
        check("l4_pulses", 32'(pulses), 32'd1);
        check("l4_valid_at", 32'(vk), 32'd4);
        check("l4_busy_cycles", 32'(busy_cnt), 32'd5);
        check("l4_result", res4, 32'hFFFF_FFFB);
        check("l4_ci1", ci1_4, 32'd20);
        check("l4_ci2", ci2_4, 32'd3);
        check("l4_acc", {24'd0, acc4}, 32'd1);
        ovr = 1'b0;

        // Reset during WAIT aborts the request
        @(negedge CLK);
        funct3 = 3'b101;
        op1    = 32'd50;
        op2    = 32'd5;
        acc    = 8'd2;
        start4 = 1'b1;
        @(posedge CLK);
        #1 start4 = 1'b0;
        @(negedge CLK);
        check("abort_busy_before", {31'd0, busy4}, 32'd1);
        check("abort_ci1_before", ci1_4, 32'd50);
        @(posedge CLK);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy4}, 32'd0);
        check("abort_valid", {31'd0, valid4}, 32'd0);
        check("abort_result", res4, 32'd0);
        check("abort_ci1", ci1_4, 32'd0);
        check("abort_ci2", ci2_4, 32'd0);
        check("abort_acc", {24'd0, acc4}, 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        pulses = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge CLK);
            if (valid4) pulses++;
        end
        check("abort_no_pulse", 32'(pulses), 32'd0);

        // Fresh request after abort
        funct3 = 3'b101;
        op1    = 32'd9;
        op2    = 32'd3;
        acc    = 8'd0;
        start4 = 1'b1;
        @(posedge CLK);
        #1 start4 = 1'b0;
        k = 0;
        @(negedge CLK);
        found = valid4;
        while (!found && k < 20) begin
            @(negedge CLK);
            k++;
            found = valid4;
        end
        check("post_valid_seen", {31'd0, found}, 32'd1);
        check("post_lat", 32'(k), 32'd4);
        check("post_result", res4, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_issue_controller.md
# divider_issue_controller

Sequential issue/completion stage wrapped around the 32-bit approximate unsigned divider core. Accepts RISC-V M-extension divide requests (DIV, DIVU, REM, REMU) from the execute stage. Resolves architectural special cases locally, and presents operand magnitudes plus an accuracy code to the core. After a fixed core latency it samples the core outputs, applies sign correction, and returns a single-cycle-valid result to writeback.

## Interface
- CORE_LATENCY, 1, cycles from core-input registration to core-output sampling; legal range 1..15.
- CLK  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; funct3[2]==0 means not a divide.
- operand_1  in  32  dividend.
- operand_2  in  32  divisor.
- accuracy_in  in  8  accuracy code forwarded to the core.
- busy  out  1  high whenever the state is not IDLE.
- result_valid  out  1  one-cycle completion strobe.
- result  out  32  quotient or remainder; holds its value until the next completion.
- core_input_1  out  32  registered dividend magnitude.
- core_input_2  out  32  registered divisor magnitude.
- core_accuracy  out  8  registered accuracy code.
- core_result  in  32  core quotient.
- core_remainder  in  32  core remainder.

## Operation
- States:
  - IDLE
  - WAIT
  - DONE
- Reset (async, any state): state=IDLE; busy, result_valid, result, core_input_1, core_input_2, core_accuracy and the counter all 0.
- IDLE: a request is accepted when start=1 and funct3[2]=1. Otherwise the block stays in IDLE and ignores the inputs.
- On accept, latch:
  - op_rem = funct3[1]
  - signed = !funct3[0]
  - neg_q = signed & (op1[31]^op2[31])
  - neg_r = signed & op1[31]
- Special case, divisor zero:
  - quotient = 0xFFFFFFFF
  - remainder = operand_1
  - go to DONE; core inputs are not updated.
- Special case, signed overflow (signed, op1=0x80000000, op2=0xFFFFFFFF):
  - quotient = 0x80000000
  - remainder = 0
  - go to DONE.
  - The divisor-zero check takes priority.
- Normal case:
  - core_input_1 = signed&op1[31] ? -op1 : op1.
  - core_input_2 is derived from op2 the same way.
  - core_accuracy = accuracy_in.
  - counter = CORE_LATENCY-1; go to WAIT.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- WAIT: counter decrements each cycle. At the edge where counter==0:
  - result = op_rem ? (neg_r ? -core_remainder : core_remainder) : (neg_q ? -core_result : core_result)
  - go to DONE.
- Sign correction is applied to whatever the core returns, including approximate (reduced-accuracy) values. All negation is 32-bit two's complement with wrap.
- DONE: result_valid=1 for exactly this cycle; next edge goes to IDLE.
- start is ignored while busy; there is no queueing.
- Core inputs stay stable from accept until the next accepted normal-case request.

## Timing
- Accepting edge = edge E at which IDLE samples start=1.
- busy rises after E and falls after the DONE cycle.
- Normal case: result_valid is high in the cycle following edge E+CORE_LATENCY. It is sampled high at edge E+CORE_LATENCY+1.
- Special case: result_valid is high in the cycle following E. It is sampled high at edge E+1.
- Throughput:
  - normal case: one request per CORE_LATENCY+2 cycles.
  - special case: one request per 2 cycles.
  - start asserted during DONE is lost.
- Reset asserted mid-operation aborts immediately. result_valid must never assert for the aborted request.
- result changes only at the edge entering DONE.

## Test plan
- Reset, then DIVU 100/7 with accuracy 0 and an ideal core, CORE_LATENCY=1 -> core_input_1=100 and core_input_2=7; result=14; valid sampled at E+2; busy high for 2 cycles.
- DIV -100/7 and REM -100/7, core returns 14/2 -> result 0xFFFFFFF2 (-14), then 0xFFFFFFFE (-2).
- DIVU 5/0 and REM 0x80000000/0 -> 0xFFFFFFFF and 0x80000000; valid at E+1; core_input_* unchanged.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- CORE_LATENCY=4, DIV 20/-3, core returns 5 (approximate, accuracy=1) -> result 0xFFFFFFFB; start pulses while busy are ignored; exactly one valid pulse at E+5.
- Reset pulsed while in WAIT -> all outputs 0 asynchronously; no valid pulse; a subsequent DIVU 9/3 -> 3.
